// File: rtl/hack_pkg.sv
// Shared definitions for the Hack computer: control states, instruction field
// layout, destination/jump bit positions and ALU comp encodings.
package hack_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam int INSTR_C_BIT = 15;
    localparam int INSTR_A_BIT = 12;
    localparam int COMP_HI     = 11;
    localparam int COMP_LO     = 6;
    localparam int DEST_HI     = 5;
    localparam int DEST_LO     = 3;
    localparam int JUMP_HI     = 2;
    localparam int JUMP_LO     = 0;

    // Bit positions inside the 3-bit dest and jump fields
    localparam int DEST_A  = 2;
    localparam int DEST_D  = 1;
    localparam int DEST_M  = 0;
    localparam int JUMP_LT = 2;
    localparam int JUMP_EQ = 1;
    localparam int JUMP_GT = 0;

    // comp field {zx,nx,zy,ny,f,no}; Y is A when a=0, M when a=1
    localparam logic [5:0] COMP_ZERO    = 6'b101010;
    localparam logic [5:0] COMP_ONE     = 6'b111111;
    localparam logic [5:0] COMP_NEG_ONE = 6'b111010;
    localparam logic [5:0] COMP_D       = 6'b001100;
    localparam logic [5:0] COMP_Y       = 6'b110000;
    localparam logic [5:0] COMP_NOT_D   = 6'b001101;
    localparam logic [5:0] COMP_NOT_Y   = 6'b110001;
    localparam logic [5:0] COMP_NEG_D   = 6'b001111;
    localparam logic [5:0] COMP_NEG_Y   = 6'b110011;
    localparam logic [5:0] COMP_D_INC   = 6'b011111;
    localparam logic [5:0] COMP_Y_INC   = 6'b110111;
    localparam logic [5:0] COMP_D_DEC   = 6'b001110;
    localparam logic [5:0] COMP_Y_DEC   = 6'b110010;
    localparam logic [5:0] COMP_D_ADD_Y = 6'b000010;
    localparam logic [5:0] COMP_D_SUB_Y = 6'b010011;
    localparam logic [5:0] COMP_Y_SUB_D = 6'b000111;
    localparam logic [5:0] COMP_D_AND_Y = 6'b000000;
    localparam logic [5:0] COMP_D_OR_Y  = 6'b010101;

    function automatic logic jump_taken(input logic [2:0] jump, input logic zr, input logic ng);
        return (jump[JUMP_LT] & ng) | (jump[JUMP_EQ] & zr) | (jump[JUMP_GT] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_system_alu.sv
// Combinational Hack ALU: operand zero/negate controls, add-or-and, output
// negate, plus zero and negative flags.
module hack_alu
    import hack_pkg::*;
(
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_zx,
    input  logic        i_nx,
    input  logic        i_zy,
    input  logic        i_ny,
    input  logic        i_f,
    input  logic        i_no,
    output logic [15:0] o_out,
    output logic        o_zr,
    output logic        o_ng
);

    logic [15:0] w_x0;
    logic [15:0] w_x1;
    logic [15:0] w_y0;
    logic [15:0] w_y1;
    logic [15:0] w_fn;

    assign w_x0  = i_zx ? 16'd0 : i_x;
    assign w_x1  = i_nx ? ~w_x0 : w_x0;
    assign w_y0  = i_zy ? 16'd0 : i_y;
    assign w_y1  = i_ny ? ~w_y0 : w_y0;
    assign w_fn  = i_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign o_out = i_no ? ~w_fn : w_fn;
    assign o_zr  = (o_out == 16'd0);
    assign o_ng  = o_out[15];

endmodule

// File: rtl/hack_system.sv
// Hack computer top: control FSM (LOAD/RUN/HALT), single-cycle CPU datapath,
// instruction ROM with a load port, data RAM and a registered RAM-write monitor.
module hack_system
    import hack_pkg::*;
#(
    parameter int ROM_AW = 10,
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ROM_AW-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    output logic              halted,
    output logic              fault,
    output logic [ROM_AW-1:0] pc,
    output logic [15:0]       instr,
    output logic [31:0]       cycle_count,
    output logic              mem_wr_valid,
    output logic [15:0]       mem_wr_addr,
    output logic [15:0]       mem_wr_data
);

    localparam int          ROM_DEPTH = 1 << ROM_AW;
    localparam int          RAM_DEPTH = 1 << RAM_AW;
    localparam logic [16:0] ROM_LIMIT = 17'(ROM_DEPTH);
    localparam logic [16:0] RAM_LIMIT = 17'(RAM_DEPTH);

    logic [15:0]       r_rom [ROM_DEPTH];
    logic [15:0]       r_ram [RAM_DEPTH];
    state_e            r_state;
    state_e            w_state_next;
    logic [ROM_AW-1:0] r_pc;
    logic [15:0]       r_a;
    logic [15:0]       r_d;
    logic [31:0]       r_cycle_count;
    logic              r_fault;
    logic              r_mem_wr_valid;
    logic [15:0]       r_mem_wr_addr;
    logic [15:0]       r_mem_wr_data;

    logic              w_is_c;
    logic              w_a_in_ram;
    logic [15:0]       w_m;
    logic [15:0]       w_alu_out;
    logic              w_alu_zr;
    logic              w_alu_ng;
    logic [2:0]        w_dest;
    logic              w_taken;
    logic [ROM_AW:0]   w_pc_inc;
    logic              w_self_jump;
    logic              w_fault_next;
    logic              w_exec;
    logic              w_ram_we;
    logic              w_rom_we;

    assign instr      = r_rom[r_pc];
    assign w_is_c     = instr[INSTR_C_BIT];
    assign w_dest     = instr[DEST_HI:DEST_LO];
    assign w_a_in_ram = ({1'b0, r_a} < RAM_LIMIT);
    assign w_m        = w_a_in_ram ? r_ram[r_a[RAM_AW-1:0]] : 16'd0;

    hack_alu u_alu (
        .i_x   (r_d),
        .i_y   (instr[INSTR_A_BIT] ? w_m : r_a),
        .i_zx  (instr[COMP_HI]),
        .i_nx  (instr[COMP_HI-1]),
        .i_zy  (instr[COMP_HI-2]),
        .i_ny  (instr[COMP_HI-3]),
        .i_f   (instr[COMP_LO+1]),
        .i_no  (instr[COMP_LO]),
        .o_out (w_alu_out),
        .o_zr  (w_alu_zr),
        .o_ng  (w_alu_ng)
    );

    // Jump target is always the pre-update A; out-of-range targets and pc wrap become faults
    assign w_taken      = w_is_c & jump_taken(instr[JUMP_HI:JUMP_LO], w_alu_zr, w_alu_ng);
    assign w_pc_inc     = {1'b0, r_pc} + {{ROM_AW{1'b0}}, 1'b1};
    assign w_self_jump  = w_taken & ({1'b0, r_a} == 17'(r_pc));
    assign w_fault_next = w_taken ? ({1'b0, r_a} >= ROM_LIMIT) : w_pc_inc[ROM_AW];

    assign w_exec   = (r_state == ST_RUN) |
                      ((r_state == ST_HALT) & step & ~start & ~r_fault);
    assign w_ram_we = w_exec & w_is_c & w_dest[DEST_M] & w_a_in_ram;
    assign w_rom_we = load_ready & load_valid & ~reset;

    assign load_ready   = (r_state == ST_LOAD);
    assign halted       = (r_state != ST_RUN);
    assign fault        = r_fault;
    assign pc           = r_pc;
    assign cycle_count  = r_cycle_count;
    assign mem_wr_valid = r_mem_wr_valid;
    assign mem_wr_addr  = r_mem_wr_addr;
    assign mem_wr_data  = r_mem_wr_data;

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; stop is honoured after the RUN instruction of that cycle executes
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (start) w_state_next = ST_RUN;
                else       w_state_next = ST_LOAD;
            end
            ST_RUN: begin
                if (w_self_jump | w_fault_next | stop) w_state_next = ST_HALT;
                else                                   w_state_next = ST_RUN;
            end
            ST_HALT: begin
                if (start & ~r_fault) w_state_next = ST_RUN;
                else                  w_state_next = ST_HALT;
            end
            default: w_state_next = ST_LOAD;
        endcase
    end

    // CPU registers: pc, A, D, executed-instruction counter and sticky fault
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= {ROM_AW{1'b0}};
            r_a           <= 16'd0;
            r_d           <= 16'd0;
            r_cycle_count <= 32'd0;
            r_fault       <= 1'b0;
        end else if (w_exec) begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (w_self_jump | w_fault_next) r_pc <= r_pc;
            else if (w_taken)               r_pc <= r_a[ROM_AW-1:0];
            else                            r_pc <= w_pc_inc[ROM_AW-1:0];
            if (!w_is_c)               r_a <= instr;
            else if (w_dest[DEST_A])   r_a <= w_alu_out;
            else                       r_a <= r_a;
            if (w_is_c & w_dest[DEST_D]) r_d <= w_alu_out;
            else                         r_d <= r_d;
            if (w_fault_next) r_fault <= 1'b1;
            else              r_fault <= r_fault;
        end else begin
            r_pc <= r_pc;
        end
    end

    // Program and data memories; contents survive reset, but reset blocks any write
    always_ff @(posedge clk) begin
        if (w_rom_we) r_rom[load_addr] <= load_data;
        if (w_ram_we & ~reset) r_ram[r_a[RAM_AW-1:0]] <= w_alu_out;
    end

    // RAM-write monitor, one-cycle strobe after each committed write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_wr_valid <= 1'b0;
            r_mem_wr_addr  <= 16'd0;
            r_mem_wr_data  <= 16'd0;
        end else begin
            r_mem_wr_valid <= w_ram_we;
            if (w_ram_we) begin
                r_mem_wr_addr <= r_a;
                r_mem_wr_data <= w_alu_out;
            end else begin
                r_mem_wr_addr <= r_mem_wr_addr;
                r_mem_wr_data <= r_mem_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_hack_system.sv
// Bench for hack_system (ROM_AW=3, RAM_AW=4): directed programs plus randomized
// control/load traffic, all checked every cycle against an instruction-level model.
module tb_hack_system;

    localparam int RAW = 3;
    localparam int MAW = 4;

    typedef enum {M_LOAD, M_RUN, M_HALT} mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset = 1'b1, load_valid = 1'b0, start = 1'b0, stop = 1'b0, step = 1'b0;
    logic [RAW-1:0] load_addr = '0;
    logic [15:0]    load_data = 16'd0;
    logic           load_ready, halted, fault, mem_wr_valid;
    logic [RAW-1:0] pc;
    logic [15:0]    instr, mem_wr_addr, mem_wr_data;
    logic [31:0]    cycle_count;

    hack_system #(.ROM_AW(RAW), .RAM_AW(MAW)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data), .start(start), .stop(stop),
        .step(step), .halted(halted), .fault(fault), .pc(pc), .instr(instr),
        .cycle_count(cycle_count), .mem_wr_valid(mem_wr_valid),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction-level) ----------------
    logic [15:0]    m_rom [8];
    logic [15:0]    m_ram [16];
    mstate_t        m_st = M_LOAD;
    logic [RAW-1:0] m_pc;
    logic [15:0]    m_a, m_d, m_wa, m_wd;
    logic [31:0]    m_cnt;
    logic           m_flt, m_wv;
    bit             m_ok = 1'b0;

    // Hack comp table written as mnemonics: X is D, Y is A or M
    function automatic logic [15:0] alu_ref(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - x;
            6'b110011: return 16'd0 - y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'd0;
        endcase
    endfunction

    task automatic model_exec(input bit halt_after);
        logic [15:0] ins, a0, res, mv;
        int npc;
        bit tk;
        ins = m_rom[m_pc];
        a0  = m_a;
        tk  = 1'b0;
        m_cnt = m_cnt + 32'd1;
        if (!ins[15]) begin
            m_a = ins;
            npc = int'(m_pc) + 1;
        end else begin
            mv  = (a0 < 16'd16) ? m_ram[a0[3:0]] : 16'd0;
            res = alu_ref(ins[11:6], m_d, ins[12] ? mv : a0);
            if (ins[5]) m_a = res;
            if (ins[4]) m_d = res;
            if (ins[3] && a0 < 16'd16) begin
                m_ram[a0[3:0]] = res;
                m_wv = 1'b1; m_wa = a0; m_wd = res;
            end
            tk  = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'd0) || (ins[0] && $signed(res) > 0);
            npc = tk ? int'(a0) : int'(m_pc) + 1;
        end
        if (tk && a0 == 16'(m_pc)) m_st = M_HALT;
        else if (npc >= 8) begin m_flt = 1'b1; m_st = M_HALT; end
        else begin
            m_pc = RAW'(npc);
            if (halt_after) m_st = M_HALT;
        end
    endtask

    always @(posedge clk) begin
        m_wv = 1'b0;
        if (reset) begin
            m_st = M_LOAD; m_pc = '0; m_a = 16'd0; m_d = 16'd0; m_cnt = 32'd0; m_flt = 1'b0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            case (m_st)
                M_LOAD: begin
                    if (load_valid) m_rom[load_addr] = load_data;
                    if (start) m_st = M_RUN;
                end
                M_RUN: model_exec(stop);
                default: begin
                    if (!m_flt && start)     m_st = M_RUN;
                    else if (!m_flt && step) model_exec(1'b1);
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    int          pulses = 0;
    logic [15:0] last_wa = 16'd0, last_wd = 16'd0;

    always @(negedge clk) begin
        if (m_ok) begin
            chk("load_ready", load_ready, m_st == M_LOAD);
            chk("halted", halted, m_st != M_RUN);
            chk("fault", fault, m_flt);
            chk("pc", pc, m_pc);
            chk("cycle_count", cycle_count, m_cnt);
            if (!$isunknown(m_rom[m_pc])) chk("instr", instr, m_rom[m_pc]);
            chk("mem_wr_valid", mem_wr_valid, m_wv);
            if (m_wv) begin
                chk("mem_wr_addr", mem_wr_addr, m_wa);
                chk("mem_wr_data", mem_wr_data, m_wd);
            end
        end
        if (mem_wr_valid) begin
            pulses++; last_wa = mem_wr_addr; last_wd = mem_wr_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; load_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic load_prog(input logic [15:0] p [8]);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); load_valid = 1'b1; load_addr = RAW'(i); load_data = p[i];
        end
        @(negedge clk); load_valid = 1'b0;
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        start = (which == 0); stop = (which == 1); step = (which == 2);
        @(negedge clk);
        start = 1'b0; stop = 1'b0; step = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        chk("halt_reached", halted, 1'b1);
        idle(2);
    endtask

    logic [5:0] comps [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                               6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                               6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

    function automatic logic [15:0] rand_instr();
        if ($urandom % 2 == 0) begin
            case ($urandom % 3)
                0:       return 16'($urandom % 8);
                1:       return 16'($urandom % 24);
                default: return {1'b0, 15'($urandom)};
            endcase
        end
        return {3'b111, 1'($urandom % 2), comps[$urandom % 18], 3'($urandom % 8), 3'($urandom % 8)};
    endfunction

    logic [15:0] p_clr [8] = '{16'h000F, 16'hEC10, 16'hE320, 16'hEA88, 16'hE390, 16'h0002, 16'hE303, 16'hEA90};
    logic [15:0] p_add [8] = '{16'h0002, 16'hEC10, 16'h0003, 16'hE090, 16'h0000, 16'hE308, 16'h0007, 16'hEA87};
    logic [15:0] p_inc [8] = '{16'hE7D0, 16'hE7D0, 16'hE7D0, 16'hE7D0, 16'hE7D0, 16'hE7D0, 16'hE7D0, 16'hE7D0};
    logic [15:0] p_oor [8] = '{16'hEE90, 16'h0014, 16'hEFC8, 16'hFC10, 16'h0000, 16'hE308, 16'h0007, 16'hEA87};
    logic [15:0] p_rnd [8];

    initial begin
        idle(2);
        reset = 1'b0;

        // Clear RAM 15..0 with a counted loop that ends by running off the ROM
        load_prog(p_clr);
        pulses = 0;
        pulse(0);
        wait_halt(300);
        chk("clr_pulses", 32'(pulses), 32'd16);
        chk("clr_fault", fault, 1'b1);

        // Basic run to self-jump
        do_reset();
        load_prog(p_add);
        pulses = 0;
        pulse(0);
        wait_halt(50);
        chk("basic_pulses", 32'(pulses), 32'd1);
        chk("basic_wr_addr", last_wa, 16'd0);
        chk("basic_wr_data", last_wd, 16'd5);
        chk("basic_pc", pc, 32'd7);
        chk("basic_count", cycle_count, 32'd8);
        chk("basic_fault", fault, 1'b0);

        // Stop and step (ROM retained, no reload)
        do_reset();
        pulses = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        idle(1);
        chk("stop_pc", pc, 32'd2);
        chk("stop_count", cycle_count, 32'd2);
        repeat (3) pulse(2);
        idle(1);
        chk("step_pc", pc, 32'd5);
        chk("step_count", cycle_count, 32'd5);
        chk("step_no_wr", 32'(pulses), 32'd0);
        pulse(2);
        idle(2);
        chk("step_pulses", 32'(pulses), 32'd1);
        chk("step_wr_addr", last_wa, 16'd0);
        chk("step_wr_data", last_wd, 16'd5);

        // Fault at end of an 8-word ROM, then start/step are ignored
        do_reset();
        load_prog(p_inc);
        pulse(0);
        wait_halt(50);
        chk("fault_flag", fault, 1'b1);
        chk("fault_pc", pc, 32'd7);
        chk("fault_count", cycle_count, 32'd8);
        pulse(0);
        pulse(2);
        idle(2);
        chk("fault_hold_pc", pc, 32'd7);
        chk("fault_hold_count", cycle_count, 32'd8);
        chk("fault_hold_halted", halted, 1'b1);

        // Reset mid-run, then resume from retained ROM
        do_reset();
        @(negedge clk); load_valid = 1'b1; load_addr = 3'd0; load_data = 16'h0000;
        @(negedge clk); load_addr = 3'd1; load_data = 16'hEA87;
        @(negedge clk); load_valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 50 && cycle_count != 32'd10; i++) @(negedge clk);
        chk("reach_count10", cycle_count, 32'd10);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rst_pc", pc, 32'd0);
        chk("rst_count", cycle_count, 32'd0);
        chk("rst_load_ready", load_ready, 1'b1);
        pulse(0);
        idle(5);
        chk("resume_running", halted, 1'b0);

        // Load requests during RUN are refused
        @(negedge clk); load_valid = 1'b1; load_addr = 3'd0; load_data = 16'hFFFF;
        idle(6);
        chk("run_load_ready", load_ready, 1'b0);
        for (int i = 0; i < 10 && pc != 3'd1; i++) @(negedge clk);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0; load_valid = 1'b0;
        chk("gate_pc", pc, 32'd0);
        chk("gate_rom0", instr, 16'h0000);

        // Load with start in the same LOAD cycle still lands
        do_reset();
        @(negedge clk); load_valid = 1'b1; load_addr = 3'd0; load_data = 16'hFFFF; start = 1'b1;
        @(negedge clk); load_valid = 1'b0; start = 1'b0;
        chk("loadstart_instr", instr, 16'hFFFF);
        idle(3);

        // Out-of-range RAM address: write dropped, read returns 0
        do_reset();
        load_prog(p_oor);
        pulses = 0;
        pulse(0);
        wait_halt(50);
        chk("oor_pulses", 32'(pulses), 32'd1);
        chk("oor_wr_addr", last_wa, 16'd0);
        chk("oor_d_zero", last_wd, 16'd0);
        chk("oor_fault", fault, 1'b0);

        // Randomized programs with random control pulses, loads and resets
        for (int prog = 0; prog < 8; prog++) begin
            do_reset();
            for (int i = 0; i < 8; i++) p_rnd[i] = rand_instr();
            load_prog(p_rnd);
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                start      = ($urandom % 8 == 0);
                stop       = ($urandom % 10 == 0);
                step       = ($urandom % 3 == 0);
                load_valid = ($urandom % 5 == 0);
                load_addr  = RAW'($urandom);
                load_data  = rand_instr();
                reset      = ($urandom % 97 == 0);
            end
            @(negedge clk);
            start = 1'b0; stop = 1'b0; step = 1'b0; load_valid = 1'b0; reset = 1'b0;
            idle(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_system.md
# hack_system

Parameterised Hack computer: a single-cycle Hack CPU with an instruction ROM and a data RAM, plus a program-load port and run/stop/step control. Programs are loaded through a ready/valid port rather than by hierarchical writes into ROM, and execution can be observed through a registered RAM-write monitor. It sits one level above the CPU/ALU and is the top that benches instantiate.

## Interface
- `ROM_AW`, 10: ROM address width; depth is 2^ROM_AW words of 16 bits; pc width is ROM_AW.
- `RAM_AW`, 10: RAM address width; depth is 2^RAM_AW words of 16 bits.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `load_valid` in 1: load request.
- `load_ready` out 1: ROM write accepted this cycle.
- `load_addr` in ROM_AW: ROM word address.
- `load_data` in 16: instruction word.
- `start` in 1: one-cycle command pulse.
- `stop` in 1: one-cycle command pulse.
- `step` in 1: one-cycle command pulse.
- `halted` out 1: high in LOAD and HALT.
- `fault` out 1: sticky pc-out-of-range error.
- `pc` out ROM_AW: program counter.
- `instr` out 16: rom[pc], combinational.
- `cycle_count` out 32: number of executed instructions.
- `mem_wr_valid` out 1: registered RAM-write monitor strobe.
- `mem_wr_addr` out 16: RAM write address.
- `mem_wr_data` out 16: RAM write data.

## Operation
- States: LOAD, RUN, HALT.
- Reset: state=LOAD; pc, A, D, cycle_count=0; fault=0; mem_wr_* = 0. ROM and RAM contents are retained across reset.
- LOAD:
  - load_ready=1.
  - A load is accepted when load_valid=1 and load_ready=1; rom[load_addr] <= load_data on that edge.
  - start moves to RUN. A load presented in the same cycle as start still completes.
  - stop and step are ignored.
- RUN:
  - load_ready=0; any load request is ignored.
  - Executes one instruction per clock.
  - stop moves to HALT; stop is evaluated after the current instruction executes.
- HALT:
  - step executes exactly one instruction and stays in HALT.
  - start moves to RUN when fault=0.
  - start and step in the same cycle: start wins; step is not executed.
  - When fault=1, start and step are ignored until reset.
- Execute, Hack ISA:
  - bit15=0: A <= instr.
  - Otherwise, format is 111a cccc ccdd djjj.
  - M = RAM[A], where A is the value before the update.
  - A RAM write uses the pre-update A.
  - The jump target is the pre-update A.
  - Destination writes to A, D and M happen on the same edge.
- Self-jump: a taken jump whose target equals pc.
  - The instruction counts as executed.
  - pc is unchanged.
  - State becomes HALT.
- Fault: the next pc (pc+1, or the jump target) is at or above 2^ROM_AW, including a target with A[15:ROM_AW] nonzero.
  - The instruction counts as executed.
  - pc holds.
  - fault=1 and state becomes HALT.
- RAM address at or above 2^RAM_AW:
  - Reads return 0.
  - Writes are dropped; there is no mem_wr pulse and no fault.
- cycle_count increments once per executed instruction and wraps at 2^32.

## Timing
- instr follows pc combinationally, with zero latency.
- An instruction executes on the edge of a cycle where state=RUN, or state=HALT with an accepted step. pc, A, D and RAM update on that edge.
- mem_wr_valid is high for exactly one cycle, the cycle after the edge that committed the RAM write. mem_wr_addr and mem_wr_data hold the committed values.
- The halted output goes high in the cycle after the edge that caused a stop, self-jump or fault.
- Reset asserted mid-run takes priority over everything, including an in-flight write. No monitor pulse follows reset.

## Structure
- Package `hack_pkg` holds:
  - the state enum;
  - instruction field positions (a, comp, dest, jump);
  - dest bit constants (A, D, M);
  - jump bit constants (LT, EQ, GT);
  - comp encodings.
- Sub-module `hack_alu`: combinational, with zx, nx, zy, ny, f and no controls and zr/ng flags.
- Control FSM, PC/A/D registers, ROM, RAM and monitor live in `hack_system`.

## Test plan
- Basic run to self-jump:
  - Stimulus: load `@2`, `D=A`, `@3`, `D=D+A`, `@0`, `M=D`, `@7`, `0;JMP` into 0..7, then start.
  - Required: one mem_wr pulse with addr=0, data=5; then halted=1, pc=7, cycle_count=8, fault=0.
- Stop and step:
  - Stimulus: same program; start, then stop one cycle later.
  - Required: pc=2, cycle_count=2 after stop. Three step pulses give pc=5, cycle_count=5. A fourth step gives a mem_wr pulse with addr 0, data 5.
- Fault with ROM_AW=3:
  - Stimulus: eight `D=D+1` instructions, then start.
  - Required: fault=1, halted=1, pc=7, cycle_count=8. A following start or step leaves all outputs unchanged.
- Reset mid-run:
  - Stimulus: program `@0`, `0;JMP`, start, assert reset at cycle_count=10.
  - Required: pc=0, cycle_count=0, load_ready=1. A start with no reload resumes the same loop, since ROM is retained.
- Load gating:
  - Stimulus: hold load_valid with load_addr=0 and load_data=16'hFFFF during RUN.
  - Required: load_ready=0 and rom[0] unchanged. In LOAD, the same request with start in the same cycle writes rom[0]=16'hFFFF.
- Out-of-range RAM with RAM_AW=4:
  - Stimulus: `@20`, `M=1`, then `D=M`.
  - Required: no mem_wr pulse; D=0.
